// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction-cache controller: bus command and
// miss-entry encodings, cachemem address widths, block-address split helpers.
package icache_ctrl_pkg;

  localparam int ICACHE_BLK_BITS = 61;
  localparam int ICACHE_IDX_BITS = 5;
  localparam int ICACHE_TAG_BITS = ICACHE_BLK_BITS - ICACHE_IDX_BITS;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  typedef enum logic [1:0] {
    MSHR_FREE    = 2'h0,
    MSHR_PENDING = 2'h1,
    MSHR_WAITING = 2'h2
  } mshr_state_e;

  // Block address B = addr[63:3]; idx is addr[3 +: IDX], tag is addr[63 -: TAG].
  function automatic logic [ICACHE_IDX_BITS-1:0] blk_idx(input logic [ICACHE_BLK_BITS-1:0] blk);
    return blk[ICACHE_IDX_BITS-1:0];
  endfunction

  function automatic logic [ICACHE_TAG_BITS-1:0] blk_tag(input logic [ICACHE_BLK_BITS-1:0] blk);
    return blk[ICACHE_BLK_BITS-1 -: ICACHE_TAG_BITS];
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Memory-side bus of the instruction cache: command/address out, accept tag,
// return tag and return data in.
interface icache_ctrl_if #(
  parameter int MEM_TAG_BITS = 4
);
  import icache_ctrl_pkg::*;

  bus_cmd_e                 proc2Imem_command;
  logic [63:0]              proc2Imem_addr;
  logic [MEM_TAG_BITS-1:0]  Imem2proc_response;
  logic [MEM_TAG_BITS-1:0]  Imem2proc_tag;
  logic [63:0]              Imem2proc_data;

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    input  Imem2proc_response, Imem2proc_tag, Imem2proc_data
  );

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    output Imem2proc_response, Imem2proc_tag, Imem2proc_data
  );

endinterface

// File: rtl/icache_mshr.sv
// Outstanding-miss entry array: allocation, issue priority and fill matching.
// Optional next-block prefetch is enabled with macro ICACHE_PREFETCH_EN.
module icache_mshr
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_MSHR     = 4,
  parameter int MEM_TAG_BITS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc_req,
  input  logic [ICACHE_BLK_BITS-1:0]  alloc_blk,
  input  logic [MEM_TAG_BITS-1:0]     mem_response,
  input  logic [MEM_TAG_BITS-1:0]     mem_tag,
  output logic                        issue_valid,
  output logic [ICACHE_BLK_BITS-1:0]  issue_blk,
  output logic                        fill_valid,
  output logic [ICACHE_BLK_BITS-1:0]  fill_blk
);

  localparam int SEL_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam logic [MEM_TAG_BITS-1:0] TAG_NONE = '0;

  mshr_state_e                state_r     [NUM_MSHR];
  mshr_state_e                state_nxt_s [NUM_MSHR];
  logic [ICACHE_BLK_BITS-1:0] blk_r       [NUM_MSHR];
  logic [ICACHE_BLK_BITS-1:0] blk_nxt_s   [NUM_MSHR];
  logic [MEM_TAG_BITS-1:0]    tag_r       [NUM_MSHR];
  logic [MEM_TAG_BITS-1:0]    tag_nxt_s   [NUM_MSHR];

  logic [SEL_W-1:0] issue_sel_s;
  logic [SEL_W-1:0] fill_sel_s;
  logic [SEL_W-1:0] free0_sel_s;
  logic             free0_valid_s;
  logic             dmd_present_s;
  logic             alloc_dmd_s;
`ifdef ICACHE_PREFETCH_EN
  logic [SEL_W-1:0]           free1_sel_s;
  logic                       free1_valid_s;
  logic                       pf_present_s;
  logic                       alloc_pf_s;
  logic [ICACHE_BLK_BITS-1:0] pf_blk_s;
`endif

  // Entry state register; reset discards every outstanding miss.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_r[i] <= MSHR_FREE;
        blk_r[i]   <= '0;
        tag_r[i]   <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      blk_r   <= blk_nxt_s;
      tag_r   <= tag_nxt_s;
    end
  end

  // Lookup and priority: descending scan so the lowest-numbered match wins.
  always_comb begin
    issue_valid   = 1'b0;
    issue_sel_s   = '0;
    fill_valid    = 1'b0;
    fill_sel_s    = '0;
    free0_valid_s = 1'b0;
    free0_sel_s   = '0;
    dmd_present_s = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      issue_sel_s   = (state_r[i] == MSHR_PENDING) ? SEL_W'(i) : issue_sel_s;
      issue_valid   = issue_valid | (state_r[i] == MSHR_PENDING);
      fill_sel_s    = (state_r[i] == MSHR_WAITING && tag_r[i] == mem_tag) ? SEL_W'(i) : fill_sel_s;
      fill_valid    = fill_valid | (state_r[i] == MSHR_WAITING && tag_r[i] == mem_tag);
      free0_sel_s   = (state_r[i] == MSHR_FREE) ? SEL_W'(i) : free0_sel_s;
      free0_valid_s = free0_valid_s | (state_r[i] == MSHR_FREE);
      dmd_present_s = dmd_present_s | (state_r[i] != MSHR_FREE && blk_r[i] == alloc_blk);
    end
    fill_valid  = fill_valid & (mem_tag != TAG_NONE);
    issue_blk   = blk_r[issue_sel_s];
    fill_blk    = blk_r[fill_sel_s];
    alloc_dmd_s = alloc_req & ~dmd_present_s & free0_valid_s;
`ifdef ICACHE_PREFETCH_EN
    pf_blk_s      = alloc_blk + ICACHE_BLK_BITS'(1);
    free1_valid_s = 1'b0;
    free1_sel_s   = '0;
    pf_present_s  = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      free1_sel_s   = (state_r[i] == MSHR_FREE && SEL_W'(i) != free0_sel_s) ? SEL_W'(i) : free1_sel_s;
      free1_valid_s = free1_valid_s | (state_r[i] == MSHR_FREE && SEL_W'(i) != free0_sel_s);
      pf_present_s  = pf_present_s | (state_r[i] != MSHR_FREE && blk_r[i] == pf_blk_s);
    end
    alloc_pf_s = alloc_dmd_s & ~pf_present_s & free1_valid_s;
`endif
  end

  // Per-entry next state: allocate, accept on nonzero response, free on fill.
  always_comb begin
    state_nxt_s = state_r;
    blk_nxt_s   = blk_r;
    tag_nxt_s   = tag_r;
    for (int i = 0; i < NUM_MSHR; i++) begin
      case (state_r[i])
        MSHR_FREE: begin
          if (alloc_dmd_s && free0_sel_s == SEL_W'(i)) begin
            state_nxt_s[i] = MSHR_PENDING;
            blk_nxt_s[i]   = alloc_blk;
`ifdef ICACHE_PREFETCH_EN
          end else if (alloc_pf_s && free1_sel_s == SEL_W'(i)) begin
            state_nxt_s[i] = MSHR_PENDING;
            blk_nxt_s[i]   = pf_blk_s;
`endif
          end else begin
            state_nxt_s[i] = MSHR_FREE;
          end
        end
        MSHR_PENDING: begin
          if (issue_valid && issue_sel_s == SEL_W'(i) && mem_response != TAG_NONE) begin
            state_nxt_s[i] = MSHR_WAITING;
            tag_nxt_s[i]   = mem_response;
          end else begin
            state_nxt_s[i] = MSHR_PENDING;
          end
        end
        MSHR_WAITING: begin
          if (fill_valid && fill_sel_s == SEL_W'(i)) begin
            state_nxt_s[i] = MSHR_FREE;
            tag_nxt_s[i]   = TAG_NONE;
          end else begin
            state_nxt_s[i] = MSHR_WAITING;
          end
        end
        default: begin
          state_nxt_s[i] = MSHR_FREE;
        end
      endcase
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: zero-latency hit, fill forwarding and port
// muxing around the miss-entry array (prefetch option: ICACHE_PREFETCH_EN).
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_MSHR     = 4,
  parameter int MEM_TAG_BITS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        proc2Icache_req,
  input  logic [63:0]                 proc2Icache_addr,
  output logic [63:0]                 Icache_data_out,
  output logic                        Icache_valid_out,
  output logic [ICACHE_IDX_BITS-1:0]  rd1_idx,
  output logic [ICACHE_TAG_BITS-1:0]  rd1_tag,
  input  logic [63:0]                 cachemem_data,
  input  logic                        cachemem_valid,
  output logic                        wr1_en,
  output logic [ICACHE_IDX_BITS-1:0]  wr1_idx,
  output logic [ICACHE_TAG_BITS-1:0]  wr1_tag,
  output logic [63:0]                 wr1_data,
  icache_ctrl_if.master               mem
);

  logic [ICACHE_BLK_BITS-1:0] req_blk_s;
  logic [ICACHE_BLK_BITS-1:0] issue_blk_s;
  logic [ICACHE_BLK_BITS-1:0] fill_blk_s;
  logic                       issue_valid_s;
  logic                       fill_valid_s;
  logic                       hit_s;
  logic                       fwd_s;
  logic                       alloc_req_s;
  logic                       addr_unused_s;

  assign req_blk_s     = proc2Icache_addr[63:3];
  assign addr_unused_s = ^proc2Icache_addr[2:0];
  assign rd1_idx       = proc2Icache_addr[3 +: ICACHE_IDX_BITS];
  assign rd1_tag       = proc2Icache_addr[63 -: ICACHE_TAG_BITS];

  icache_mshr #(
    .NUM_MSHR     (NUM_MSHR),
    .MEM_TAG_BITS (MEM_TAG_BITS)
  ) u_mshr (
    .clock        (clock),
    .reset        (reset),
    .alloc_req    (alloc_req_s),
    .alloc_blk    (req_blk_s),
    .mem_response (mem.Imem2proc_response),
    .mem_tag      (mem.Imem2proc_tag),
    .issue_valid  (issue_valid_s),
    .issue_blk    (issue_blk_s),
    .fill_valid   (fill_valid_s),
    .fill_blk     (fill_blk_s)
  );

  // Hit beats forward; a miss is only raised when neither supplies the block.
  always_comb begin
    hit_s            = proc2Icache_req & cachemem_valid & reset;
    fwd_s            = proc2Icache_req & ~hit_s & fill_valid_s & (fill_blk_s == req_blk_s);
    alloc_req_s      = proc2Icache_req & ~hit_s & ~fwd_s;
    Icache_valid_out = hit_s | fwd_s;
    if (hit_s) begin
      Icache_data_out = cachemem_data;
    end else if (fwd_s) begin
      Icache_data_out = mem.Imem2proc_data;
    end else begin
      Icache_data_out = 64'h0;
    end
  end

  // Cachemem fill port and memory command muxing.
  always_comb begin
    wr1_en   = fill_valid_s;
    wr1_idx  = blk_idx(fill_blk_s);
    wr1_tag  = blk_tag(fill_blk_s);
    wr1_data = mem.Imem2proc_data;
    if (issue_valid_s) begin
      mem.proc2Imem_command = BUS_LOAD;
      mem.proc2Imem_addr    = {issue_blk_s, 3'b000};
    end else begin
      mem.proc2Imem_command = BUS_NONE;
      mem.proc2Imem_addr    = 64'h0;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed scoreboard bench for icache_ctrl; prefetch expectations follow
// ICACHE_PREFETCH_EN.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  logic                       clock = 1'b0;
  logic                       reset = 1'b0;
  logic                       proc2Icache_req = 1'b0;
  logic [63:0]                proc2Icache_addr = 64'h0;
  logic [63:0]                Icache_data_out;
  logic                       Icache_valid_out;
  logic [ICACHE_IDX_BITS-1:0] rd1_idx;
  logic [ICACHE_TAG_BITS-1:0] rd1_tag;
  logic [63:0]                cachemem_data = 64'h0;
  logic                       cachemem_valid = 1'b0;
  logic                       wr1_en;
  logic [ICACHE_IDX_BITS-1:0] wr1_idx;
  logic [ICACHE_TAG_BITS-1:0] wr1_tag;
  logic [63:0]                wr1_data;

  icache_ctrl_if #(.MEM_TAG_BITS(4)) mem_bus();

  icache_ctrl #(.NUM_MSHR(4), .MEM_TAG_BITS(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2Icache_req  (proc2Icache_req),
    .proc2Icache_addr (proc2Icache_addr),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .rd1_idx          (rd1_idx),
    .rd1_tag          (rd1_tag),
    .cachemem_data    (cachemem_data),
    .cachemem_valid   (cachemem_valid),
    .wr1_en           (wr1_en),
    .wr1_idx          (wr1_idx),
    .wr1_tag          (wr1_tag),
    .wr1_data         (wr1_data),
    .mem              (mem_bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        req;
    logic [63:0] addr;
    logic        cv;
    logic [63:0] cd;
    logic [3:0]  resp;
    logic [3:0]  rtag;
    logic [63:0] rd;
  } stim_t;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [1:0]  cmd;
    logic [63:0] ma;
    logic        wr;
    logic [63:0] wd;
    logic [63:0] wa;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, name, obs, exp);
    end
  endtask

  function automatic stim_t st(input logic rst, input logic req, input logic [63:0] addr,
                               input logic cv, input logic [63:0] cd, input logic [3:0] resp,
                               input logic [3:0] rtag, input logic [63:0] rd);
    stim_t s;
    s.rst = rst; s.req = req; s.addr = addr; s.cv = cv; s.cd = cd;
    s.resp = resp; s.rtag = rtag; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t sreq(input logic [63:0] addr, input logic [3:0] resp,
                                 input logic [3:0] rtag, input logic [63:0] rd);
    return st(1'b1, 1'b1, addr, 1'b0, 64'h0, resp, rtag, rd);
  endfunction

  function automatic stim_t snone(input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rd);
    return st(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, resp, rtag, rd);
  endfunction

  function automatic exp_t ex(input logic v, input logic [63:0] d, input logic [1:0] cmd,
                              input logic [63:0] ma, input logic wr, input logic [63:0] wd,
                              input logic [63:0] wa);
    exp_t e;
    e.v = v; e.d = d; e.cmd = cmd; e.ma = ma; e.wr = wr; e.wd = wd; e.wa = wa;
    return e;
  endfunction

  function automatic exp_t ex_idle();
    return ex(1'b0, 64'h0, BUS_NONE, 64'h0, 1'b0, 64'h0, 64'h0);
  endfunction

  function automatic exp_t ex_load(input logic [63:0] ma);
    return ex(1'b0, 64'h0, BUS_LOAD, ma, 1'b0, 64'h0, 64'h0);
  endfunction

  task automatic cyc(input stim_t s, input exp_t e);
    exp_t x;
    @(posedge clock);
    #1;
    reset                      = s.rst;
    proc2Icache_req            = s.req;
    proc2Icache_addr           = s.addr;
    cachemem_valid             = s.cv;
    cachemem_data              = s.cd;
    mem_bus.Imem2proc_response = s.resp;
    mem_bus.Imem2proc_tag      = s.rtag;
    mem_bus.Imem2proc_data     = s.rd;
    sb.push_back(e);
    @(negedge clock);
    x = sb.pop_front();
    check_eq("valid", 64'(Icache_valid_out), 64'(x.v));
    if (x.v) check_eq("data", Icache_data_out, x.d);
    check_eq("cmd", 64'(mem_bus.proc2Imem_command), 64'(x.cmd));
    check_eq("mem_addr", mem_bus.proc2Imem_addr, x.ma);
    check_eq("wr1_en", 64'(wr1_en), 64'(x.wr));
    if (x.wr) begin
      check_eq("wr1_data", wr1_data, x.wd);
      check_eq("wr1_idx", 64'(wr1_idx), 64'(x.wa[7:3]));
      check_eq("wr1_tag", 64'(wr1_tag), 64'(x.wa[63:8]));
    end
    check_eq("rd1_idx", 64'(rd1_idx), 64'(s.addr[7:3]));
    check_eq("rd1_tag", 64'(rd1_tag), 64'(s.addr[63:8]));
  endtask

  initial begin
    mem_bus.Imem2proc_response = 4'h0;
    mem_bus.Imem2proc_tag      = 4'h0;
    mem_bus.Imem2proc_data     = 64'h0;

    phase = "reset";
    cyc(st(1'b0, 1'b1, 64'h1000, 1'b1, 64'h1111, 4'h0, 4'h0, 64'h0), ex_idle());

    phase = "hit";
    cyc(st(1'b1, 1'b1, 64'h1000, 1'b1, 64'h1111, 4'h0, 4'h0, 64'h0),
        ex(1'b1, 64'h1111, BUS_NONE, 64'h0, 1'b0, 64'h0, 64'h0));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_idle());

`ifndef ICACHE_PREFETCH_EN
    phase = "miss_retry";
    cyc(sreq(64'h2000, 4'h0, 4'h0, 64'h0), ex_idle());
    cyc(snone(4'h0, 4'h0, 64'h0), ex_load(64'h2000));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_load(64'h2000));
    cyc(snone(4'h3, 4'h0, 64'h0), ex_load(64'h2000));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_idle());
    cyc(sreq(64'h2000, 4'h0, 4'h3, 64'hDEAD),
        ex(1'b1, 64'hDEAD, BUS_NONE, 64'h0, 1'b1, 64'hDEAD, 64'h2000));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_idle());

    phase = "repeat_miss";
    cyc(sreq(64'h2008, 4'h0, 4'h0, 64'h0), ex_idle());
    cyc(sreq(64'h2008, 4'h0, 4'h0, 64'h0), ex_load(64'h2008));
    cyc(snone(4'h2, 4'h0, 64'h0), ex_load(64'h2008));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_idle());
    cyc(snone(4'h0, 4'h2, 64'hBEEF), ex(1'b0, 64'h0, BUS_NONE, 64'h0, 1'b1, 64'hBEEF, 64'h2008));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_idle());

    phase = "full";
    cyc(sreq(64'h4000, 4'h0, 4'h0, 64'h0), ex_idle());
    for (int i = 1; i <= 4; i++) begin
      cyc(sreq(64'h4000 + 64'(i * 8), 4'h0, 4'h0, 64'h0), ex_load(64'h4000));
    end
    cyc(snone(4'h6, 4'h0, 64'h0), ex_load(64'h4000));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_load(64'h4008));
    cyc(sreq(64'h4020, 4'h0, 4'h6, 64'hAAAA),
        ex(1'b0, 64'h0, BUS_LOAD, 64'h4008, 1'b1, 64'hAAAA, 64'h4000));
    cyc(sreq(64'h4020, 4'h7, 4'h0, 64'h0), ex_load(64'h4008));
    cyc(snone(4'h0, 4'h0, 64'h0), ex_load(64'h4020));
    cyc(st(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 4'h0, 4'h0, 64'h0), ex_idle());
`endif

    phase = "reset_mid";
    cyc(sreq(64'h5000, 4'h0, 4'h0, 64'h0), ex_idle());
    cyc(snone(4'h5, 4'h0, 64'h0), ex_load(64'h5000));
    cyc(st(1'b0, 1'b1, 64'h5000, 1'b1, 64'h77, 4'h0, 4'h0, 64'h0), ex_idle());
    cyc(snone(4'h0, 4'h5, 64'h5555), ex_idle());
    cyc(snone(4'h0, 4'h0, 64'h0), ex_idle());

    phase = "prefetch";
    cyc(sreq(64'h3000, 4'h0, 4'h0, 64'h0), ex_idle());
    cyc(snone(4'h1, 4'h0, 64'h0), ex_load(64'h3000));
`ifdef ICACHE_PREFETCH_EN
    cyc(snone(4'h2, 4'h0, 64'h0), ex_load(64'h3008));
    cyc(snone(4'h0, 4'h1, 64'h33), ex(1'b0, 64'h0, BUS_NONE, 64'h0, 1'b1, 64'h33, 64'h3000));
    cyc(snone(4'h0, 4'h2, 64'h44), ex(1'b0, 64'h0, BUS_NONE, 64'h0, 1'b1, 64'h44, 64'h3008));
`else
    cyc(snone(4'h2, 4'h0, 64'h0), ex_idle());
    cyc(snone(4'h0, 4'h1, 64'h33), ex(1'b0, 64'h0, BUS_NONE, 64'h0, 1'b1, 64'h33, 64'h3000));
    cyc(snone(4'h0, 4'h2, 64'h44), ex_idle());
`endif
    cyc(snone(4'h0, 4'h0, 64'h0), ex_idle());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter NUM_MSHR, default 4, number of outstanding-miss entries (power of 2, 2..8).
REQ-002 Parameter MEM_TAG_BITS, default 4, width of memory transaction tag; tag value 0 means "none".
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-005 proc2Icache_req  in  1  fetch request valid.
REQ-006 proc2Icache_addr  in  64  fetch byte address; bits [2:0] ignored.
REQ-007 Icache_data_out  out  64  fetched block data.
REQ-008 Icache_valid_out  out  1  Icache_data_out valid this cycle.
REQ-009 rd1_idx / rd1_tag  out  `ICACHE_IDX_BITS / `ICACHE_TAG_BITS  cachemem lookup address.
REQ-010 cachemem_data / cachemem_valid  in  64 / 1  cachemem lookup result.
REQ-011 wr1_en / wr1_idx / wr1_tag / wr1_data  out  1 / IDX / TAG / 64  cachemem fill port.
REQ-012 proc2Imem_command / proc2Imem_addr  out  2 / 64  memory command (BUS_NONE/BUS_LOAD), block-aligned address.
REQ-013 Imem2proc_response / Imem2proc_tag  in  MEM_TAG_BITS each  request-accept tag / data-return tag.
REQ-014 Imem2proc_data  in  64  returned block data, valid when Imem2proc_tag != 0.

Function
REQ-015 Address split SHALL be idx = addr[3 +: IDX_BITS], tag = addr[63 -: TAG_BITS]; block address B = addr[63:3].
REQ-016 rd1_idx/rd1_tag SHALL be driven combinationally from proc2Icache_addr every cycle.
REQ-017 Hit: Icache_valid_out SHALL be req & cachemem_valid, Icache_data_out = cachemem_data, zero latency.
REQ-018 Forward: if no hit and a fill completes this cycle for B, Icache_valid_out SHALL be 1 with Icache_data_out = Imem2proc_data.
REQ-019 Each MSHR entry SHALL hold state FREE, PENDING (not yet accepted) or WAITING (accepted), plus B and memory tag.
REQ-020 Miss (req, no hit, no forward, B not in any non-FREE entry) SHALL allocate the lowest-numbered FREE entry as PENDING; if none free, miss is dropped and Icache_valid_out = 0.
REQ-021 Each cycle the lowest-numbered PENDING entry SHALL drive proc2Imem_command = BUS_LOAD, proc2Imem_addr = {B,3'b0}; none pending gives BUS_NONE, address 0.
REQ-022 Imem2proc_response != 0 in an issue cycle SHALL move that entry to WAITING with tag = response; response 0 retries next cycle unchanged.
REQ-023 Imem2proc_tag != 0 matching a WAITING entry SHALL assert wr1_en that cycle with idx/tag from its B, wr1_data = Imem2proc_data, and free the entry at next edge.
REQ-024 Unmatched nonzero Imem2proc_tag SHALL be ignored (wr1_en = 0).
REQ-025 An entry freed this cycle SHALL NOT be reallocated until the following cycle; allocate and fill of different entries in one cycle are both performed.
REQ-026 Address changes SHALL NOT cancel outstanding entries; their fills still write cachemem.
REQ-027 At most one allocation per cycle without prefetch, one BUS_LOAD issue and one fill per cycle always.

Reset
REQ-028 While reset is low: all entries FREE, proc2Imem_command = BUS_NONE, proc2Imem_addr = 0, wr1_en = 0, Icache_valid_out = 0.
REQ-029 Reset asserted mid-transaction SHALL discard all entries; later returns for their tags are ignored per REQ-024.

Configuration
REQ-030 Macro ICACHE_PREFETCH_EN defined: a demand allocation of B SHALL also allocate B+1 (61-bit wrap) in the next-lowest FREE entry in the same cycle if B+1 is absent and an entry is free; demand issues first.
REQ-031 Macro undefined: no prefetch logic; only demand misses allocate.

Structure
REQ-032 BUS_NONE/BUS_LOAD encodings, MSHR state encoding and ICACHE_* widths SHALL live in the shared sys_defs header.
REQ-033 The entry array with allocate/lookup/priority logic SHALL be sub-module icache_mshr; icache_ctrl holds hit/forward and port muxing.

Verification
REQ-034 Hit: cachemem_valid=1, addr 0x1000 -> Icache_valid_out=1 same cycle, no BUS_LOAD.
REQ-035 Miss 0x2000, response 0 twice then 3, tag 3 returns data 0xDEAD -> BUS_LOAD 0x2000 three cycles, wr1_en one cycle with data 0xDEAD, forwarded valid.
REQ-036 Five distinct misses, no returns -> four entries allocated, fifth dropped; after one fill, fifth allocates next cycle.
REQ-037 Repeat miss 0x2008 while outstanding -> no second allocation.
REQ-038 Reset low between accept and return of tag 5 -> no wr1_en on tag-5 return.
REQ-039 ICACHE_PREFETCH_EN, miss 0x3000 -> BUS_LOAD 0x3000 then 0x3008.
